regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 153 +++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: two 2-deep write-back queues (A = ALU, B = load) merged round-robin onto one
// register-file write port, with pending-write hazard flags. Optional forwarding under WB_BYPASS_EN.
`default_nettype none

module regfile_wb_arbiter (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        a_valid,
    input  logic [4:0]  a_rd,
    input  logic [31:0] a_data,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [4:0]  b_rd,
    input  logic [31:0] b_data,
    output logic        b_ready,
    output logic        regWrite,
    output logic [4:0]  rd,
    output logic [31:0] regWriteData,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
`ifdef WB_BYPASS_EN
    output logic [31:0] fwd_rs_data,
    output logic [31:0] fwd_rt_data,
    output logic        fwd_rs,
    output logic        fwd_rt,
`endif
    output logic        hazard_rs,
    output logic        hazard_rt
);

    // Index 0 = source A, 1 = source B; entry 0 of each queue is the head.
    logic [1:0][1:0][4:0]  fifo_rd_q,   fifo_rd_d;
    logic [1:0][1:0][31:0] fifo_data_q, fifo_data_d;
    logic [1:0][1:0]       cnt_q,       cnt_d;
    logic                  last_b_q,    last_b_d;
    logic                  we_q,        we_d;
    logic [4:0]            wb_rd_q,     wb_rd_d;
    logic [31:0]           wb_data_q,   wb_data_d;

    logic [1:0]            in_valid;
    logic [1:0][4:0]       in_rd;
    logic [1:0][31:0]      in_data;
    logic [1:0]            ready, push, pop;
    logic [1:0][1:0]       vld;
    logic [1:0][1:0]       after_pop;
    logic [4:0]            head_rd;
    logic [31:0]           head_data;
    logic                  fifo_hit_rs, fifo_hit_rt, out_hit_rs, out_hit_rt;

    assign in_valid = {b_valid, a_valid};
    assign in_rd    = {b_rd, a_rd};
    assign in_data  = {b_data, a_data};

    always_comb begin
        fifo_rd_d   = fifo_rd_q;
        fifo_data_d = fifo_data_q;
        cnt_d       = cnt_q;
        last_b_d    = last_b_q;
        we_d        = 1'b0;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        ready       = '0;
        push        = '0;
        vld         = '0;
        after_pop   = '0;
        fifo_hit_rs = 1'b0;
        fifo_hit_rt = 1'b0;

        for (int s = 0; s < 2; s++) begin
            ready[s]  = RST_N && (cnt_q[s] != 2'd2);
            push[s]   = in_valid[s] && ready[s];
            vld[s][0] = (cnt_q[s] != 2'd0);
            vld[s][1] = (cnt_q[s] == 2'd2);
        end

        // On a tie the source that did not win last time is served; pointer moves only on ties.
        pop[0] = vld[0][0] && (!vld[1][0] || last_b_q);
        pop[1] = vld[1][0] && (!vld[0][0] || !last_b_q);
        if (vld[0][0] && vld[1][0]) begin
            last_b_d = pop[1];
        end

        head_rd   = pop[1] ? fifo_rd_q[1][0]   : fifo_rd_q[0][0];
        head_data = pop[1] ? fifo_data_q[1][0] : fifo_data_q[0][0];
        if (pop[0] || pop[1]) begin
            we_d      = (head_rd != 5'd0);
            wb_rd_d   = head_rd;
            wb_data_d = head_data;
        end

        for (int s = 0; s < 2; s++) begin
            after_pop[s] = cnt_q[s] - {1'b0, pop[s]};
            if (pop[s]) begin
                fifo_rd_d[s][0]   = fifo_rd_q[s][1];
                fifo_data_d[s][0] = fifo_data_q[s][1];
            end
            // A push lands behind whatever survives this cycle's pop.
            if (push[s]) begin
                fifo_rd_d[s][after_pop[s][0]]   = in_rd[s];
                fifo_data_d[s][after_pop[s][0]] = in_data[s];
            end
            cnt_d[s] = after_pop[s] + {1'b0, push[s]};
            for (int i = 0; i < 2; i++) begin
                if (vld[s][i] && (fifo_rd_q[s][i] == rs)) fifo_hit_rs = 1'b1;
                if (vld[s][i] && (fifo_rd_q[s][i] == rt)) fifo_hit_rt = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            fifo_rd_q   <= '0;
            fifo_data_q <= '0;
            cnt_q       <= '0;
            last_b_q    <= 1'b1;
            we_q        <= 1'b0;
            wb_rd_q     <= 5'd0;
            wb_data_q   <= 32'd0;
        end else begin
            fifo_rd_q   <= fifo_rd_d;
            fifo_data_q <= fifo_data_d;
            cnt_q       <= cnt_d;
            last_b_q    <= last_b_d;
            we_q        <= we_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
        end
    end

    assign a_ready      = ready[0];
    assign b_ready      = ready[1];
    assign regWrite     = we_q;
    assign rd           = wb_rd_q;
    assign regWriteData = wb_data_q;
    assign out_hit_rs   = we_q && (wb_rd_q == rs);
    assign out_hit_rt   = we_q && (wb_rd_q == rt);

`ifdef WB_BYPASS_EN
    // The committing value can be forwarded unless a younger queued write targets the same register.
    assign fwd_rs      = (rs != 5'd0) && out_hit_rs && !fifo_hit_rs;
    assign fwd_rt      = (rt != 5'd0) && out_hit_rt && !fifo_hit_rt;
    assign fwd_rs_data = wb_data_q;
    assign fwd_rt_data = wb_data_q;
    assign hazard_rs   = (rs != 5'd0) && fifo_hit_rs;
    assign hazard_rt   = (rt != 5'd0) && fifo_hit_rt;
`else
    assign hazard_rs   = (rs != 5'd0) && (fifo_hit_rs || out_hit_rs);
    assign hazard_rt   = (rt != 5'd0) && (fifo_hit_rt || out_hit_rt);
`endif

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed vector table, hand-written corner sequences,
// and randomized traffic compared against a queue-based reference model.
`default_nettype none

module tb_regfile_wb_arbiter;
    logic        CLK = 1'b0;
    logic        RST_N;
    logic        a_valid, b_valid, a_ready, b_ready;
    logic [4:0]  a_rd, b_rd, rd, rs, rt;
    logic [31:0] a_data, b_data, regWriteData;
    logic        regWrite, hazard_rs, hazard_rt;

    always #5 CLK = ~CLK;

    regfile_wb_arbiter dut (
        .CLK(CLK), .RST_N(RST_N),
        .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
        .regWrite(regWrite), .rd(rd), .regWriteData(regWriteData),
        .rs(rs), .rt(rt), .hazard_rs(hazard_rs), .hazard_rt(hazard_rt)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] d;
    } ent_t;

    typedef struct {
        logic        a_v;
        logic [4:0]  a_rd;
        logic [31:0] a_d;
        logic        b_v;
        logic [4:0]  b_rd;
        logic [31:0] b_d;
        logic        e_we;
        logic        e_chk;
        logic [4:0]  e_rd;
        logic [31:0] e_d;
    } vec_t;

    // Reference model: per-source queues, last-granted source, and the committed write.
    ent_t        qa[$], qb[$];
    bit          last_b;
    logic        m_we;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    bit          acc_a, acc_b;
    int          n_chk, n_fail;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic bit haz(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        foreach (qa[i]) if (qa[i].rd == r) return 1'b1;
        foreach (qb[i]) if (qb[i].rd == r) return 1'b1;
        return m_we && (m_rd == r);
    endfunction

    task automatic model_reset();
        qa.delete();
        qb.delete();
        last_b = 1'b1;
        m_we   = 1'b0;
        m_rd   = 5'd0;
        m_data = 32'd0;
        acc_a  = 1'b0;
        acc_b  = 1'b0;
    endtask

    // Called just after a falling edge with inputs applied; returns at the next falling edge.
    task automatic step();
        ent_t e;
        bit   pa, pb;
        #1;
        chk("a_ready", a_ready, qa.size() < 2);
        chk("b_ready", b_ready, qb.size() < 2);
        chk("hazard_rs", hazard_rs, haz(rs));
        chk("hazard_rt", hazard_rt, haz(rt));
        acc_a = a_valid && (qa.size() < 2);
        acc_b = b_valid && (qb.size() < 2);
        @(posedge CLK);
        pa = 1'b0;
        pb = 1'b0;
        e  = '{5'd0, 32'd0};
        if (qa.size() > 0 && qb.size() > 0) begin
            if (last_b) pa = 1'b1; else pb = 1'b1;
            last_b = pb;
        end else if (qa.size() > 0) pa = 1'b1;
        else if (qb.size() > 0) pb = 1'b1;
        if (pa) e = qa.pop_front();
        else if (pb) e = qb.pop_front();
        if (pa || pb) begin
            m_we   = (e.rd != 5'd0);
            m_rd   = e.rd;
            m_data = e.d;
        end else begin
            m_we = 1'b0;
        end
        if (acc_a) qa.push_back('{a_rd, a_data});
        if (acc_b) qb.push_back('{b_rd, b_data});
        #1;
        chk("regWrite", regWrite, m_we);
        if (m_we) begin
            chk("rd", rd, m_rd);
            chk("regWriteData", regWriteData, m_data);
        end
        @(negedge CLK);
    endtask

    task automatic idle_inputs();
        a_valid = 1'b0; a_rd = 5'd0; a_data = 32'd0;
        b_valid = 1'b0; b_rd = 5'd0; b_data = 32'd0;
    endtask

    vec_t tbl[12];
    int   b_seen[$];
    int   bi;
    bit   saw_low;

    initial begin
        n_chk  = 0;
        n_fail = 0;
        RST_N  = 1'b0;
        rs     = 5'd0;
        rt     = 5'd0;
        idle_inputs();
        model_reset();

        tbl[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 5'd0, 32'd0};
        tbl[1]  = '{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF};
        tbl[2]  = '{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF};
        tbl[3]  = '{1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF};
        tbl[4]  = '{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 5'd1, 32'h11};
        tbl[5]  = '{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 5'd2, 32'h22};
        tbl[6]  = '{1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, 1'b0, 1'b1, 5'd2, 32'h22};
        tbl[7]  = '{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 5'd4, 32'h44};
        tbl[8]  = '{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 5'd3, 32'h33};
        tbl[9]  = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 5'd3, 32'h33};
        tbl[10] = '{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0};
        tbl[11] = '{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0};

        // Reset values
        repeat (2) @(negedge CLK);
        chk("rst_a_ready", a_ready, 1'b0);
        chk("rst_b_ready", b_ready, 1'b0);
        chk("rst_regWrite", regWrite, 1'b0);
        chk("rst_rd", rd, 5'd0);
        chk("rst_data", regWriteData, 32'd0);
        RST_N = 1'b1;

        // Directed table: single write, two ties with alternating winner, rd==0 discard
        foreach (tbl[i]) begin
            a_valid = tbl[i].a_v; a_rd = tbl[i].a_rd; a_data = tbl[i].a_d;
            b_valid = tbl[i].b_v; b_rd = tbl[i].b_rd; b_data = tbl[i].b_d;
            step();
            chk($sformatf("tbl%0d_we", i), regWrite, tbl[i].e_we);
            if (tbl[i].e_chk) begin
                chk($sformatf("tbl%0d_rd", i), rd, tbl[i].e_rd);
                chk($sformatf("tbl%0d_data", i), regWriteData, tbl[i].e_d);
            end
        end

        // Hazard held from queueing through the commit cycle, cleared afterwards
        rs = 5'd7;
        a_valid = 1'b1; a_rd = 5'd7; a_data = 32'h77;
        step();
        idle_inputs();
        chk("haz_queued", hazard_rs, 1'b1);
        step();
        chk("haz_commit_we", regWrite, 1'b1);
        chk("haz_commit", hazard_rs, 1'b1);
        step();
        chk("haz_after", hazard_rs, 1'b0);
        rs = 5'd0;

        // Backpressure: A saturating, B must stall and still deliver all four entries in order
        bi = 0;
        saw_low = 1'b0;
        b_seen.delete();
        a_valid = 1'b1; a_rd = 5'd20; a_data = $urandom;
        for (int c = 0; c < 40 && bi < 4; c++) begin
            b_valid = 1'b1; b_rd = 5'(10 + bi); b_data = 32'hB000_0000 + 32'(bi);
            #1;
            if (!b_ready) saw_low = 1'b1;
            step();
            if (regWrite && rd >= 5'd10 && rd <= 5'd13) b_seen.push_back(int'(rd));
            if (acc_b) bi++;
            if (acc_a) begin a_rd = 5'(20 + ($urandom % 4)); a_data = $urandom; end
        end
        idle_inputs();
        for (int c = 0; c < 8; c++) begin
            step();
            if (regWrite && rd >= 5'd10 && rd <= 5'd13) b_seen.push_back(int'(rd));
        end
        chk("bp_ready_low", saw_low, 1'b1);
        chk("bp_b_count", b_seen.size(), 4);
        for (int k = 0; k < 4 && k < b_seen.size(); k++)
            chk($sformatf("bp_b_order%0d", k), b_seen[k], 10 + k);

        // Reset mid-operation with queued traffic
        rs = 5'd9; rt = 5'd10;
        a_valid = 1'b1; a_rd = 5'd9;  a_data = 32'h99;
        b_valid = 1'b1; b_rd = 5'd10; b_data = 32'hAA;
        repeat (3) step();
        RST_N = 1'b0;
        #1;
        chk("mid_rst_a_ready", a_ready, 1'b0);
        chk("mid_rst_b_ready", b_ready, 1'b0);
        chk("mid_rst_regWrite", regWrite, 1'b0);
        chk("mid_rst_rd", rd, 5'd0);
        chk("mid_rst_data", regWriteData, 32'd0);
        chk("mid_rst_haz_rs", hazard_rs, 1'b0);
        chk("mid_rst_haz_rt", hazard_rt, 1'b0);
        @(negedge CLK);
        RST_N = 1'b1;
        idle_inputs();
        model_reset();
        for (int c = 0; c < 5; c++) begin
            step();
            chk("post_rst_no_write", regWrite, 1'b0);
        end

        // Randomized traffic; a source keeps its request stable until accepted
        for (int c = 0; c < 500; c++) begin
            if (!a_valid || acc_a) begin
                a_valid = ($urandom % 3) != 0; a_rd = 5'($urandom % 8); a_data = $urandom;
            end
            if (!b_valid || acc_b) begin
                b_valid = ($urandom % 3) != 0; b_rd = 5'($urandom % 8); b_data = $urandom;
            end
            rs = 5'($urandom % 8);
            rt = 5'($urandom % 8);
            step();
        end
        idle_inputs();
        repeat (6) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
